ahb_gpio_irq: RTL and testbench



---
 rtl/ahb_gpio_irq.sv | 183 ++++++++++++++++++
 tb/tb_ahb_gpio_irq.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO slave: WIDTH-bit output/direction registers, synchronised inputs, edge IRQs with W1C status.
// Latency: zero-wait-state bus; pin edge -> IRQ_STATUS after SYNC_STAGES+1 edges, irq after SYNC_STAGES+2.
// Backpressure: none; HREADYOUT is tied high and a transfer is never stalled or errored.
//
// Ports:
//   HCLK, HRESET                     bus clock, asynchronous active-high reset
//   HSEL, HREADY, HADDR, HTRANS,
//   HWRITE, HSIZE, HWDATA            AHB-Lite slave inputs (only HADDR[5:0], HTRANS[1], HSIZE[1:0] decoded)
//   HRDATA, HREADYOUT                AHB-Lite slave outputs
//   gpio_in                          asynchronous pin inputs
//   gpio_out, gpio_oe                pin output value and per-bit drive enable
//   irq                              registered interrupt request to the NVIC
module ahb_gpio_irq #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic             HREADY,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [3:0] OFF_DOUT   = 4'h0;
  localparam logic [3:0] OFF_DIR    = 4'h1;
  localparam logic [3:0] OFF_DIN    = 4'h2;
  localparam logic [3:0] OFF_RISE   = 4'h3;
  localparam logic [3:0] OFF_FALL   = 4'h4;
  localparam logic [3:0] OFF_MASK   = 4'h5;
  localparam logic [3:0] OFF_STATUS = 4'h6;
  localparam logic [3:0] OFF_TGL    = 4'h7;

  // Address-phase capture
  logic [5:0] addr_q;
  logic [1:0] size_q;
  logic       write_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else if (HREADY) begin
      addr_q  <= HADDR[5:0];
      size_q  <= HSIZE[1:0];
      write_q <= HSEL & HWRITE & HTRANS[1];
    end
  end

  // Byte-lane decode; misaligned or unsupported sizes produce no lanes at all
  logic [3:0]  lanes;
  logic [31:0] wmask;

  always_comb begin
    lanes = 4'b0000;
    case (size_q)
      2'd0: lanes = 4'b0001 << addr_q[1:0];
      2'd1: begin
        if (addr_q[1:0] == 2'd0)      lanes = 4'b0011;
        else if (addr_q[1:0] == 2'd2) lanes = 4'b1100;
      end
      2'd2: if (addr_q[1:0] == 2'd0) lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
  end

  assign wmask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};

  // The data phase ends on the first edge with HREADY high
  logic             wr_en;
  logic [WIDTH-1:0] wm;
  logic [WIDTH-1:0] wd;

  assign wr_en = write_q & HREADY;
  assign wm    = wmask[WIDTH-1:0];
  assign wd    = HWDATA[WIDTH-1:0];

  logic wr_dout, wr_dir, wr_rise, wr_fall, wr_mask, wr_status, wr_tgl;
  assign wr_dout   = wr_en && (addr_q[5:2] == OFF_DOUT);
  assign wr_dir    = wr_en && (addr_q[5:2] == OFF_DIR);
  assign wr_rise   = wr_en && (addr_q[5:2] == OFF_RISE);
  assign wr_fall   = wr_en && (addr_q[5:2] == OFF_FALL);
  assign wr_mask   = wr_en && (addr_q[5:2] == OFF_MASK);
  assign wr_status = wr_en && (addr_q[5:2] == OFF_STATUS);
  assign wr_tgl    = wr_en && (addr_q[5:2] == OFF_TGL);

  // Control registers
  logic [WIDTH-1:0] dout_q, dir_q, rise_en_q, fall_en_q, mask_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dout_q    <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      mask_q    <= '0;
    end else begin
      if (wr_dout)     dout_q    <= (dout_q & ~wm) | (wd & wm);
      else if (wr_tgl) dout_q    <= dout_q ^ (wd & wm);
      if (wr_dir)      dir_q     <= (dir_q & ~wm) | (wd & wm);
      if (wr_rise)     rise_en_q <= (rise_en_q & ~wm) | (wd & wm);
      if (wr_fall)     fall_en_q <= (fall_en_q & ~wm) | (wd & wm);
      if (wr_mask)     mask_q    <= (mask_q & ~wm) | (wd & wm);
    end
  end

  // Input synchroniser and edge detection
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= data_in;
    end
  end

  assign data_in = sync_q[SYNC_STAGES-1];

  logic [WIDTH-1:0] rise, fall, set_bits, w1c_bits;
  assign rise     = data_in & ~prev_q;
  assign fall     = ~data_in & prev_q;
  assign set_bits = (rise & rise_en_q) | (fall & fall_en_q);
  assign w1c_bits = wr_status ? (wd & wm) : '0;

  // Status: a new edge in the same cycle as its W1C keeps the bit set
  logic [WIDTH-1:0] status_q;
  logic             irq_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= (status_q & ~w1c_bits) | set_bits;
      irq_q    <= |(status_q & mask_q);
    end
  end

  // Read mux: shows register contents before the edge that ends the data phase
  logic [WIDTH-1:0] rd;

  always_comb begin
    rd = '0;
    case (addr_q[5:2])
      OFF_DOUT:   rd = dout_q;
      OFF_DIR:    rd = dir_q;
      OFF_DIN:    rd = data_in;
      OFF_RISE:   rd = rise_en_q;
      OFF_FALL:   rd = fall_en_q;
      OFF_MASK:   rd = mask_q;
      OFF_STATUS: rd = status_q;
      default:    rd = '0;
    endcase
    HRDATA           = '0;
    HRDATA[WIDTH-1:0] = rd;
  end

  assign HREADYOUT = 1'b1;
  assign gpio_out  = dout_q;
  assign gpio_oe   = dir_q;
  assign irq       = irq_q;

  // Undecoded bus bits and lanes above WIDTH
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:6], HTRANS[0], HSIZE[2], HWDATA, wmask};

endmodule

// File: tb/tb_ahb_gpio_irq.sv
module tb_ahb_gpio_irq;

  logic        HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET, HSEL32, HSEL8, HREADY, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA32, HRDATA8;
  logic        HREADYOUT32, HREADYOUT8;
  logic [31:0] gpio_in32, gpio_out32, gpio_oe32;
  logic [7:0]  gpio_in8, gpio_out8, gpio_oe8;
  logic        irq32, irq8;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        exp_irq_q[$];

  ahb_gpio_irq #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL32), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA32), .HREADYOUT(HREADYOUT32), .gpio_in(gpio_in32),
    .gpio_out(gpio_out32), .gpio_oe(gpio_oe32), .irq(irq32)
  );

  ahb_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL8), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA8), .HREADYOUT(HREADYOUT8), .gpio_in(gpio_in8),
    .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
  );

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_idle();
    HSEL32 = 1'b0; HSEL8 = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic bus_write(input bit to8, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] data);
    HSEL32 = !to8; HSEL8 = to8; HADDR = addr; HSIZE = size; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input bit to8, input logic [31:0] addr, output logic [31:0] data);
    HSEL32 = !to8; HSEL8 = to8; HADDR = addr; HSIZE = 3'd2; HWRITE = 1'b0; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    bus_idle();
    data = to8 ? HRDATA8 : HRDATA32;
  endtask

  task automatic test_reset();
    logic [31:0] rd, exp;
    checks++;
    if (gpio_oe32 !== 32'h0 || gpio_out32 !== 32'h0 || irq32 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs32: oe=%h out=%h irq=%b required all 0", gpio_oe32, gpio_out32, irq32);
    end
    checks++;
    if (gpio_oe8 !== 8'h0 || irq8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs8: oe=%h irq=%b required 0", gpio_oe8, irq8);
    end
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back(32'h0);
      bus_read(1'b0, 32'(a * 4), rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL reset_read32 off=%0h: got %h required %h", a * 4, rd, exp);
      end
    end
    for (int a = 0; a < 8; a++) begin
      exp_q.push_back(32'h0);
      bus_read(1'b1, 32'(a * 4), rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL reset_read8 off=%0h: got %h required %h", a * 4, rd, exp);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, exp;
    bus_write(1'b0, 32'h01, 3'd0, 32'h0000A500);
    bus_write(1'b0, 32'h02, 3'd1, 32'h12340000);
    exp_q.push_back(32'h1234A500);
    bus_read(1'b0, 32'h00, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp || gpio_out32 !== exp) begin
      errors++;
      $display("FAIL byte_halfword: read %h pins %h required %h", rd, gpio_out32, exp);
    end
    bus_write(1'b0, 32'h02, 3'd2, 32'hFFFFFFFF);   // misaligned word
    bus_write(1'b0, 32'h01, 3'd1, 32'hFFFFFFFF);   // misaligned halfword
    bus_write(1'b0, 32'h00, 3'd3, 32'hFFFFFFFF);   // unsupported size
    exp_q.push_back(32'h1234A500);
    bus_read(1'b0, 32'h00, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL misaligned_ignored: got %h required %h", rd, exp);
    end
  endtask

  task automatic test_dir_width8();
    logic [31:0] rd, exp;
    bus_write(1'b1, 32'h04, 3'd2, 32'hFFFFFFFF);
    exp_q.push_back(32'h000000FF);
    bus_read(1'b1, 32'h04, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp || gpio_oe8 !== 8'hFF) begin
      errors++;
      $display("FAIL dir_width8: read %h oe %h required %h", rd, gpio_oe8, exp);
    end
    checks++;
    if (gpio_oe32 !== 32'h0) begin
      errors++;
      $display("FAIL dir_unselected32: oe %h required 0", gpio_oe32);
    end
  endtask

  task automatic test_toggle();
    logic [31:0] rd, exp;
    bus_write(1'b0, 32'h00, 3'd2, 32'h000000F0);
    bus_write(1'b0, 32'h1C, 3'd2, 32'h00000FF0);
    exp_q.push_back(32'h00000F00);
    bus_read(1'b0, 32'h00, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp || gpio_out32 !== exp) begin
      errors++;
      $display("FAIL toggle: read %h pins %h required %h", rd, gpio_out32, exp);
    end
    exp_q.push_back(32'h0);
    bus_read(1'b0, 32'h1C, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL toggle_read: got %h required %h", rd, exp);
    end
  endtask

  task automatic test_irq_rise();
    logic [31:0] rd, exp;
    logic        exp_irq;
    bus_write(1'b0, 32'h0C, 3'd2, 32'h1);
    bus_write(1'b0, 32'h14, 3'd2, 32'h1);
    // Pin rises just after edge n; hold a continuous status read from here.
    gpio_in32[0] = 1'b1;
    HSEL32 = 1'b1; HADDR = 32'h18; HSIZE = 3'd2; HWRITE = 1'b0; HTRANS = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(k >= 3 ? 32'h1 : 32'h0);
      exp_irq_q.push_back(k >= 4);
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge HCLK); #1;
      exp = exp_q.pop_front();
      exp_irq = exp_irq_q.pop_front();
      checks++;
      if (HRDATA32 !== exp || irq32 !== exp_irq) begin
        errors++;
        $display("FAIL rise_timing n+%0d: status %h irq %b required %h %b", k, HRDATA32, irq32, exp, exp_irq);
      end
    end
    bus_idle();
    bus_write(1'b0, 32'h18, 3'd2, 32'h1);
    checks++;
    if (irq32 !== 1'b1) begin
      errors++;
      $display("FAIL w1c_irq_lag: irq %b required 1", irq32);
    end
    @(posedge HCLK); #1;
    checks++;
    if (irq32 !== 1'b0) begin
      errors++;
      $display("FAIL w1c_irq_drop: irq %b required 0", irq32);
    end
    exp_q.push_back(32'h0);
    bus_read(1'b0, 32'h18, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL w1c_status: got %h required %h", rd, exp);
    end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] rd, exp;
    bus_write(1'b0, 32'h10, 3'd2, 32'h8);
    gpio_in32[3] = 1'b1;
    repeat (4) @(posedge HCLK);
    #1;
    gpio_in32[3] = 1'b0;                              // edge n
    @(posedge HCLK); #1;                              // n+1: W1C address phase
    HSEL32 = 1'b1; HADDR = 32'h18; HSIZE = 3'd2; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge HCLK); #1;                              // n+2: data phase
    bus_idle();
    HWDATA = 32'h8;
    @(posedge HCLK); #1;                              // n+3: set and W1C together
    exp_q.push_back(32'h8);
    bus_read(1'b0, 32'h18, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL w1c_collision: got %h required %h", rd, exp);
    end
    bus_write(1'b0, 32'h18, 3'd2, 32'h8);
    exp_q.push_back(32'h0);
    bus_read(1'b0, 32'h18, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL w1c_after_collision: got %h required %h", rd, exp);
    end
  endtask

  task automatic test_width8_irq();
    logic [31:0] rd, exp;
    bus_write(1'b1, 32'h0C, 3'd2, 32'h80);
    gpio_in8[7] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge HCLK); #1;
      checks++;
      if (irq8 !== 1'b0) begin
        errors++;
        $display("FAIL masked_irq8 n+%0d: irq %b required 0", k, irq8);
      end
    end
    exp_q.push_back(32'h80);
    bus_read(1'b1, 32'h18, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL masked_status8: got %h required %h", rd, exp);
    end
    exp_q.push_back(32'h80);
    bus_read(1'b1, 32'h08, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL data_in8: got %h required %h", rd, exp);
    end
    bus_write(1'b1, 32'h14, 3'd2, 32'h80);
    checks++;
    if (irq8 !== 1'b0) begin
      errors++;
      $display("FAIL unmask_lag8: irq %b required 0", irq8);
    end
    @(posedge HCLK); #1;
    checks++;
    if (irq8 !== 1'b1) begin
      errors++;
      $display("FAIL unmask_irq8: irq %b required 1", irq8);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp;
    exp_q.push_back(32'h00005A5A);
    exp_q.push_back(32'h0000A5A5);
    HSEL32 = 1'b1; HSIZE = 3'd2; HTRANS = 2'b10;
    HADDR = 32'h0C; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HWDATA = 32'h00005A5A; HADDR = 32'h10;
    @(posedge HCLK); #1;
    HWDATA = 32'h0000A5A5; HADDR = 32'h0C; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    bus_idle();
    rd = HRDATA32;
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL b2b_rise: got %h required %h", rd, exp);
    end
    bus_read(1'b0, 32'h10, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL b2b_fall: got %h required %h", rd, exp);
    end
  endtask

  task automatic test_reset_midtransfer();
    logic [31:0] rd, exp;
    HSEL32 = 1'b1; HADDR = 32'h00; HSIZE = 3'd2; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = 32'hDEADBEEF;
    #2 HRESET = 1'b1;
    #2 HRESET = 1'b0;
    @(posedge HCLK); #1;
    checks++;
    if (gpio_out32 !== 32'h0 || gpio_oe8 !== 8'h0 || irq8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out32 %h oe8 %h irq8 %b required 0", gpio_out32, gpio_oe8, irq8);
    end
    repeat (4) @(posedge HCLK);
    #1;
    exp_q.push_back(32'h1);
    bus_read(1'b0, 32'h08, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL post_reset_din32: got %h required %h", rd, exp);
    end
    exp_q.push_back(32'h0);
    bus_read(1'b0, 32'h18, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL post_reset_status32: got %h required %h", rd, exp);
    end
    exp_q.push_back(32'h0);
    bus_read(1'b1, 32'h18, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL post_reset_status8: got %h required %h", rd, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HADDR = '0; HWDATA = '0; HSIZE = 3'd2;
    gpio_in32 = '0; gpio_in8 = '0;
    bus_idle();
    repeat (2) @(posedge HCLK);
    #1;
    test_reset();
    test_byte_lanes();
    test_dir_width8();
    test_toggle();
    test_irq_rise();
    test_w1c_collision();
    test_width8_irq();
    test_back_to_back();
    test_reset_midtransfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
